// File: rtl/hardtanh_grad_if.sv
// Stream bundle for hardtanh_grad: forward-sample push, upstream gradient in, gated gradient out.
// The slave modport is the gradient gate; the master modport is the surrounding datapath.
interface hardtanh_grad_if #(
  parameter int DATA_W = 8
);
  logic              fwd_valid;
  logic              fwd_ready;
  logic [DATA_W-1:0] fwd_x;
  logic              grad_in_valid;
  logic              grad_in_ready;
  logic [DATA_W-1:0] grad_in;
  logic              grad_out_valid;
  logic              grad_out_ready;
  logic [DATA_W-1:0] grad_out;

  modport slave (
    input  fwd_valid, fwd_x, grad_in_valid, grad_in, grad_out_ready,
    output fwd_ready, grad_in_ready, grad_out_valid, grad_out
  );

  modport master (
    output fwd_valid, fwd_x, grad_in_valid, grad_in, grad_out_ready,
    input  fwd_ready, grad_in_ready, grad_out_valid, grad_out
  );
endinterface

// File: rtl/hardtanh_grad.sv
// HardTanh backward gate: forward samples leave a pass/block bit in a mask FIFO; gradients pop it in order.
// Define HTGRAD_STRICT_BOUND_EN to make the linear region open, so samples at exactly +/-1.0 block.
module hardtanh_grad #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hardtanh_grad_if.slave         bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Q2.6-style format: DATA_W-2 fractional bits, so +/-1.0 is 01 / 11 followed by zeros.
  localparam logic signed [DATA_W-1:0] POS_ONE = {2'b01, {(DATA_W-2){1'b0}}};
  localparam logic signed [DATA_W-1:0] NEG_ONE = {2'b11, {(DATA_W-2){1'b0}}};

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              mask_mem [DEPTH];
  logic              out_valid_q;
  logic [DATA_W-1:0] out_q;

  logic              push;
  logic              pop;
  logic              in_mask;
  logic              rd_mask;
  logic signed [DATA_W-1:0] x_s;

  always_comb begin
    x_s = $signed(bus.fwd_x);
`ifdef HTGRAD_STRICT_BOUND_EN
    in_mask = (x_s > NEG_ONE) && (x_s < POS_ONE);
`else
    in_mask = (x_s >= NEG_ONE) && (x_s <= POS_ONE);
`endif
  end

  assign rd_mask            = mask_mem[rd_ptr];
  assign bus.fwd_ready      = (cnt_q != FULL_CNT);
  assign bus.grad_in_ready  = (cnt_q != '0) && (!out_valid_q || bus.grad_out_ready);
  assign push               = bus.fwd_valid && bus.fwd_ready;
  assign pop                = bus.grad_in_valid && bus.grad_in_ready;
  assign bus.grad_out_valid = out_valid_q;
  assign bus.grad_out       = out_q;
  assign count              = cnt_q;

  // NOTE: the mask storage has no reset; count and the pointers define which entries are live,
  // so stale bits are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mask_mem[wr_ptr] <= in_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase

      // A pop always reloads the output; otherwise an accepted output simply drains.
      if (pop) begin
        out_valid_q <= 1'b1;
        out_q       <= rd_mask ? bus.grad_in : '0;
      end else if (bus.grad_out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hardtanh_grad.sv
// Directed bench for hardtanh_grad: vector table for the basic/boundary/stall cases,
// then hand-written fill, empty, streaming and reset sequences against a queue model.
module tb_hardtanh_grad;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] count;
  int            checks = 0;
  int            errors = 0;

  hardtanh_grad_if #(.DATA_W(DW)) bus ();

  hardtanh_grad #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic mask_of(input logic [DW-1:0] x);
    int v;
    v = int'($signed(x));
`ifdef HTGRAD_STRICT_BOUND_EN
    return (v > -64) && (v < 64);
`else
    return (v >= -64) && (v <= 64);
`endif
  endfunction

  task automatic drive(input logic fv, input logic [DW-1:0] x, input logic gv,
                       input logic [DW-1:0] g, input logic gor);
    bus.fwd_valid      = fv;
    bus.fwd_x          = x;
    bus.grad_in_valid  = gv;
    bus.grad_in        = g;
    bus.grad_out_ready = gor;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          push;
    logic [DW-1:0] x;
    logic          pop;
    logic [DW-1:0] g;
    logic          gor;
    logic          e_gir;
    logic          e_v;
    logic [DW-1:0] e_out;
    logic [CW-1:0] e_cnt;
  } vec_t;

`ifdef HTGRAD_STRICT_BOUND_EN
  localparam logic [DW-1:0] B1 = 8'h00;
  localparam logic [DW-1:0] B2 = 8'h00;
`else
  localparam logic [DW-1:0] B1 = 8'h7F;
  localparam logic [DW-1:0] B2 = 8'h80;
`endif

  vec_t tbl [20];

  logic          mq [$];
  logic [DW-1:0] eq [$];
  logic [DW-1:0] xs [11];

  initial begin
    logic          do_push, do_pop, do_acc, m;
    logic [DW-1:0] x, g, e;
    int            budget;

    tbl[0]  = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1};
    tbl[1]  = '{1'b1, 8'h50, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd2};
    tbl[2]  = '{1'b1, 8'hB0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd3};
    tbl[3]  = '{1'b1, 8'hE0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd4};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 5'd3};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h00, 5'd2};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h00, 5'd1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44, 5'd0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44, 5'd0};
    tbl[9]  = '{1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44, 5'd1};
    tbl[10] = '{1'b1, 8'hC0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44, 5'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, B1,    5'd1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h80, 1'b1, 1'b1, 1'b1, B2,    5'd0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, B2,    5'd0};
    tbl[14] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, B2,    5'd1};
    tbl[15] = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, B2,    5'd2};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h05, 5'd1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h05, 5'd1};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h06, 5'd0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h06, 5'd0};

    xs = '{8'h20, 8'h50, 8'hB0, 8'hE0, 8'h40, 8'hC0, 8'h41, 8'hBF, 8'h00, 8'h7F, 8'h80};

    // Reset state
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid", 32'(bus.grad_out_valid), 32'd0);
    check("reset_out", 32'(bus.grad_out), 32'd0);
    check("reset_fwd_ready", 32'(bus.fwd_ready), 32'd1);
    check("reset_gir", 32'(bus.grad_in_ready), 32'd0);
    rst = 1'b0;

    // Vector table: basic gating, boundaries, output stall
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].push, tbl[i].x, tbl[i].pop, tbl[i].g, tbl[i].gor);
      #1;
      check($sformatf("tbl%0d_gir", i), 32'(bus.grad_in_ready), 32'(tbl[i].e_gir));
      tick();
      check($sformatf("tbl%0d_valid", i), 32'(bus.grad_out_valid), 32'(tbl[i].e_v));
      check($sformatf("tbl%0d_out", i), 32'(bus.grad_out), 32'(tbl[i].e_out));
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);

    // Fill to DEPTH with alternating pass/block samples, then try one extra push
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, (i % 2 == 0) ? 8'h10 : 8'h60, 1'b0, '0, 1'b1);
      tick();
    end
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_fwd_ready", 32'(bus.fwd_ready), 32'd0);
    drive(1'b1, 8'h60, 1'b0, '0, 1'b1);
    tick();
    check("full_extra_push_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 8'(i + 1), 1'b1);
      tick();
      check($sformatf("fill_pop%0d", i), 32'(bus.grad_out),
            (i % 2 == 0) ? 32'(i + 1) : 32'd0);
    end
    check("fill_drained_count", 32'(count), 32'd0);

    // Empty: gradient must stall until one sample has been pushed
    drive(1'b0, '0, 1'b1, 8'h33, 1'b1);
    tick();
    check("empty_gir", 32'(bus.grad_in_ready), 32'd0);
    check("empty_no_output", 32'(bus.grad_out_valid), 32'd0);
    drive(1'b1, 8'h10, 1'b1, 8'h33, 1'b1);
    #1;
    check("push_cycle_gir", 32'(bus.grad_in_ready), 32'd0);
    tick();
    drive(1'b0, '0, 1'b1, 8'h33, 1'b1);
    #1;
    check("next_cycle_gir", 32'(bus.grad_in_ready), 32'd1);
    tick();
    check("empty_first_valid", 32'(bus.grad_out_valid), 32'd1);
    check("empty_first_out", 32'(bus.grad_out), 32'h33);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    tick();

    // Streaming with random downstream backpressure against a queue model
    budget = 0;
    for (int k = 0; k < 3 * DEPTH + 4 * DEPTH; k++) begin
      if (k >= 3 * DEPTH && mq.size() == 0 && eq.size() == 0) break;
      budget++;
      x = xs[$urandom_range(0, 10)];
      g = 8'(k * 3 + 1);
      drive(k < 3 * DEPTH, x, 1'b1, g,
            (k >= 3 * DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)));
      #1;
      check($sformatf("stream%0d_count", k), 32'(count), 32'(mq.size()));
      do_acc  = bus.grad_out_valid && bus.grad_out_ready;
      do_pop  = bus.grad_in_valid && bus.grad_in_ready;
      do_push = bus.fwd_valid && bus.fwd_ready;
      if (do_acc) begin
        if (eq.size() == 0) begin
          check($sformatf("stream%0d_unexpected_out", k), 32'(bus.grad_out_valid), 32'd0);
        end else begin
          e = eq.pop_front();
          check($sformatf("stream%0d_out", k), 32'(bus.grad_out), 32'(e));
        end
      end
      if (do_pop) begin
        if (mq.size() == 0) begin
          check($sformatf("stream%0d_pop_when_empty", k), 32'(do_pop), 32'd0);
        end else begin
          m = mq.pop_front();
          eq.push_back(m ? g : 8'h00);
        end
      end
      if (do_push) mq.push_back(mask_of(x));
      tick();
    end
    check("stream_drained_masks", 32'(mq.size()), 32'd0);
    check("stream_drained_outputs", 32'(eq.size()), 32'd0);
    check("stream_final_count", 32'(count), 32'd0);
    check("stream_final_valid", 32'(bus.grad_out_valid), 32'd0);

    // Reset while holding count = 5 and a stalled output
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'h10, 1'b0, '0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 8'h55, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    check("prereset_count", 32'(count), 32'd5);
    check("prereset_valid", 32'(bus.grad_out_valid), 32'd1);
    rst = 1'b1;
    drive(1'b1, 8'h10, 1'b1, 8'h66, 1'b0);
    tick();
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_valid", 32'(bus.grad_out_valid), 32'd0);
    check("midreset_fwd_ready", 32'(bus.fwd_ready), 32'd1);
    check("midreset_gir", 32'(bus.grad_in_ready), 32'd0);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hardtanh_grad.md
# hardtanh_grad

Backward-pass companion to the int8 HardTanh activation: a streaming gradient gate for training/fine-tuning datapaths. During the forward pass it captures one pass/block mask bit per pre-activation sample in an internal FIFO. During the backward pass it consumes upstream gradients in the same order and emits each gradient unchanged when its sample was inside the linear region, or zero when it was clipped. Sits between the loss/upstream gradient stream and the preceding layer's weight-update logic.

## Interface
- DATA_W, 8, sample and gradient width; signed, Q2.6 fixed point (+1.0 = 8'h40, -1.0 = 8'hC0).
- DEPTH, 16, mask FIFO depth in entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- fwd_valid  in  1  forward sample present.
- fwd_ready  out  1  mask FIFO can accept a sample.
- fwd_x  in  DATA_W  signed forward pre-activation sample.
- grad_in_valid  in  1  upstream gradient present.
- grad_in_ready  out  1  gradient accepted this cycle.
- grad_in  in  DATA_W  signed upstream gradient.
- grad_out_valid  out  1  output gradient present.
- grad_out_ready  in  1  downstream can accept.
- grad_out  out  DATA_W  signed gated gradient.
- count  out  $clog2(DEPTH)+1  mask entries currently stored.

## Operation
- Forward push: when fwd_valid && fwd_ready, write mask bit m = (fwd_x >= -1.0) && (fwd_x <= +1.0), using a signed compare, to the write pointer, and advance it.
- Backward pop: when grad_in_valid && grad_in_ready, read the mask at the read pointer, advance it, and load the output register.
  - grad_out = m ? grad_in : 0.
  - The output register always gets grad_out_valid = 1 on a pop.
- Order is strictly FIFO: the k-th accepted gradient pairs with the k-th accepted forward sample.
- Handshakes:
  - fwd_ready = (count != DEPTH).
  - grad_in_ready = (count != 0) && (!grad_out_valid || grad_out_ready).
  - There is no same-cycle bypass. A sample pushed in cycle t is poppable from cycle t+1.
  - grad_out_valid clears when grad_out_ready is high and no pop occurs in the same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy.
- Push and pop in the same cycle leave count unchanged. Both pointers advance.
- Full (count == DEPTH): fwd_ready = 0, and the push is ignored even if fwd_valid is high.
- Empty (count == 0): grad_in_ready = 0, and gradients stall.
- Output stall: grad_out, grad_out_valid and the internal state hold while grad_out_valid && !grad_out_ready.
- Gradient values are never rescaled or saturated. The output is a pure pass or zero.

## Timing
- Reset values: grad_out_valid = 0, grad_out = 0, count = 0, pointers = 0.
  - fwd_ready = 1 after reset.
  - grad_in_ready = 0 after reset.
- Reset mid-operation discards all stored masks and any pending output on the next clock edge. The mask RAM contents need not be cleared.
- Latency is 1 cycle from an accepted grad_in to grad_out_valid.
- Throughput is 1 gradient per cycle when the FIFO is non-empty and downstream is ready.
- fwd_ready, grad_in_ready and count are combinational functions of registered state. grad_in_ready also depends on grad_out_ready.

## Configuration
- HTGRAD_STRICT_BOUND_EN
  - Defined: the linear region is open, m = (fwd_x > -1.0) && (fwd_x < +1.0). Samples exactly equal to ±1.0 block the gradient.
  - Undefined (default): the region is closed as in Operation. Samples equal to ±1.0 pass the gradient, matching the forward unit, which passes ±1.0 unclipped.

## Test plan
- Push fwd_x = 8'h20, 8'h50, 8'hB0, 8'hE0, then grads 8'h11, 8'h22, 8'h33, 8'h44 -> grad_out = 8'h11, 8'h00, 8'h00, 8'h44, each 1 cycle after acceptance.
- Boundary: push 8'h40 and 8'hC0, then grads 8'h7F and 8'h80.
  - Macro undefined -> 8'h7F, 8'h80.
  - Macro defined -> 8'h00, 8'h00.
- Fill with DEPTH pushes -> count = DEPTH, fwd_ready = 0. An extra push is ignored, and pops return the DEPTH original masks in order.
- Empty FIFO with grad_in_valid = 1 -> grad_in_ready = 0 and no output. Push one sample: grad_in_ready rises the next cycle.
- Continuous push and pop for 3×DEPTH cycles with random grad_out_ready -> no loss, duplication or reordering; count stays constant during simultaneous cycles; pointers wrap.
- Assert rst with count = 5 and grad_out_valid = 1 stalled -> the next cycle shows count = 0, grad_out_valid = 0, fwd_ready = 1.
